// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared control encodings and VGA timing limits
package pong_pkg;

  typedef enum logic [1:0] {
    CTRL_HOLD = 2'b00,
    CTRL_UP   = 2'b01,
    CTRL_DOWN = 2'b10,
    CTRL_LOAD = 2'b11
  } ctrl_e;

  localparam int H_LIMIT = 799;
  localparam int V_LIMIT = 524;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides qualified cycles down to count steps
module tick_prescaler
  import pong_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int PS_WIDTH = $clog2(PRESCALE + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic qualify,
  input  logic clear,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      // No divider: every qualified cycle is a step, so the register inputs go unused.
      logic [PS_WIDTH-1:0] unused_bypass;
      assign unused_bypass = {PS_WIDTH{clk ^ reset_n ^ clear}};
      assign step = qualify;
    end else begin : g_count
      localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

      logic [PS_WIDTH-1:0] ps;

      assign step = qualify && (ps == PS_LAST);

      // Count qualified cycles; restart on a step or an external clear, hold otherwise.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          ps <= '0;
        end else if (clear || step) begin
          ps <= '0;
        end else if (qualify) begin
          ps <= ps + PS_WIDTH'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down/load counter with runtime limit, prescaler and cascade carry
module mode_counter
  import pong_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int PRESCALE = 1,
  parameter int PS_WIDTH = $clog2(PRESCALE + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       ctrl,
  input  logic             cnt_in,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             carry_out,
  output logic             roll,
  output logic             at_max,
  output logic             at_zero
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             roll_r;
  logic             is_up;
  logic             is_down;
  logic             qualify;
  logic             step;

  assign is_up   = (ctrl == CTRL_UP);
  assign is_down = (ctrl == CTRL_DOWN);
  assign qualify = (is_up || is_down) && cnt_in;

  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_WIDTH (PS_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .qualify (qualify),
    .clear   (ctrl == CTRL_LOAD),
    .step    (step)
  );

  // The terminal event is reported even when saturating; the down clamp from above limit is not terminal.
  assign carry_out = step && ((is_up && (q_r >= limit)) || (is_down && (q_r == '0)));

  assign Q       = q_r;
  assign roll    = roll_r;
  assign at_max  = (q_r == limit);
  assign at_zero = (q_r == '0);

  // Next count: range checks come before the +/-1 so the arithmetic never overflows.
  always_comb begin
    q_next = q_r;
    case (ctrl)
      CTRL_LOAD: q_next = load_val;
      CTRL_UP: begin
        if (step) begin
          if (q_r < limit) begin
            q_next = q_r + WIDTH'(1);
          end else begin
            q_next = wrap_en ? '0 : limit;
          end
        end
      end
      CTRL_DOWN: begin
        if (step) begin
          if (q_r > limit) begin
            q_next = limit;
          end else if (q_r == '0) begin
            q_next = wrap_en ? limit : '0;
          end else begin
            q_next = q_r - WIDTH'(1);
          end
        end
      end
      default: q_next = q_r;
    endcase
  end

  // Count register and single-cycle roll pulse, written on the same edge as the wrapped value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_r    <= '0;
      roll_r <= 1'b0;
    end else begin
      q_r    <= q_next;
      roll_r <= carry_out && wrap_en;
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - self-checking bench for mode_counter
module tb_mode_counter;
  import pong_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [1:0] ctrl;
  logic       cnt_in;
  logic       wrap_en;
  logic [9:0] limit;
  logic [9:0] load_val;

  logic [1:0] ctrl_b;
  logic       wrap_b;
  logic [9:0] limit_b;
  logic [9:0] load_b;

  logic [9:0] q_a, q_b, q_c;
  logic carry_a, roll_a, max_a, zero_a;
  logic carry_b, roll_b, max_b, zero_b;
  logic carry_c, roll_c, max_c, zero_c;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state for instance A (index 0, prescale 1) and C (index 1, prescale 4).
  int mq[2]  = '{0, 0};
  int mps[2] = '{0, 0};
  int mr[2]  = '{0, 0};
  int pres[2] = '{1, 4};

  mode_counter #(.WIDTH(10), .PRESCALE(1)) u_a (
    .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .cnt_in(cnt_in), .wrap_en(wrap_en),
    .limit(limit), .load_val(load_val), .Q(q_a), .carry_out(carry_a), .roll(roll_a),
    .at_max(max_a), .at_zero(zero_a)
  );

  mode_counter #(.WIDTH(10), .PRESCALE(1)) u_b (
    .clk(clk), .reset_n(reset_n), .ctrl(ctrl_b), .cnt_in(carry_a), .wrap_en(wrap_b),
    .limit(limit_b), .load_val(load_b), .Q(q_b), .carry_out(carry_b), .roll(roll_b),
    .at_max(max_b), .at_zero(zero_b)
  );

  mode_counter #(.WIDTH(10), .PRESCALE(4)) u_c (
    .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .cnt_in(cnt_in), .wrap_en(wrap_en),
    .limit(limit), .load_val(load_val), .Q(q_c), .carry_out(carry_c), .roll(roll_c),
    .at_max(max_c), .at_zero(zero_c)
  );

  function automatic bit m_qual();
    return ((ctrl == CTRL_UP) || (ctrl == CTRL_DOWN)) && cnt_in;
  endfunction

  // A step happens on the PRESCALE-th qualified cycle since the last step/load/reset.
  function automatic bit m_step(int i);
    return m_qual() && (mps[i] + 1 == pres[i]);
  endfunction

  function automatic bit m_carry(int i);
    return m_step(i) && (((ctrl == CTRL_UP) && (mq[i] >= int'(limit))) ||
                         ((ctrl == CTRL_DOWN) && (mq[i] == 0)));
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit c;
      bit s;
      int lim;
      c = m_carry(i);
      s = m_step(i);
      lim = int'(limit);
      if (!reset_n) begin
        mq[i] = 0; mps[i] = 0; mr[i] = 0;
      end else if (ctrl == CTRL_LOAD) begin
        mq[i] = int'(load_val); mps[i] = 0; mr[i] = 0;
      end else begin
        if (m_qual()) mps[i] = s ? 0 : mps[i] + 1;
        if (s && ctrl == CTRL_UP) begin
          if (mq[i] < lim) mq[i] = mq[i] + 1;
          else mq[i] = wrap_en ? 0 : lim;
        end else if (s && ctrl == CTRL_DOWN) begin
          if (mq[i] > lim) mq[i] = lim;
          else if (mq[i] == 0) mq[i] = wrap_en ? lim : 0;
          else mq[i] = mq[i] - 1;
        end
        mr[i] = (c && wrap_en) ? 1 : 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ctrl = CTRL_LOAD; cnt_in = 1'b1; wrap_en = 1'b1;
    limit = 10'd5; load_val = 10'd7;
    ctrl_b = CTRL_HOLD; wrap_b = 1'b1; limit_b = 10'd524; load_b = 10'd0;
    tick();
    reset_n = 1'b1; ctrl = CTRL_HOLD;
    #1;
    n_total++; if (q_a !== 10'd0) $display("FAIL reset_q_a got %0d exp 0", q_a); else n_pass++;
    n_total++; if (q_c !== 10'd0) $display("FAIL reset_q_c got %0d exp 0", q_c); else n_pass++;
    n_total++; if (q_b !== 10'd0) $display("FAIL reset_q_b got %0d exp 0", q_b); else n_pass++;
    n_total++; if (roll_a !== 1'b0) $display("FAIL reset_roll got %b exp 0", roll_a); else n_pass++;
    n_total++; if (zero_a !== 1'b1) $display("FAIL reset_at_zero got %b exp 1", zero_a); else n_pass++;
    n_total++; if (max_a !== 1'b0) $display("FAIL reset_at_max got %b exp 0", max_a); else n_pass++;
  endtask

  task automatic test_cascade();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    ctrl = CTRL_UP; cnt_in = 1'b1; wrap_en = 1'b1; limit = 10'(H_LIMIT);
    ctrl_b = CTRL_UP; wrap_b = 1'b1; limit_b = 10'(V_LIMIT);
    for (int i = 0; i < 800; i++) begin
      #1;
      n_total++; if (q_a !== 10'(i)) $display("FAIL casc_q_a cyc %0d got %0d exp %0d", i, q_a, i); else n_pass++;
      n_total++; if (carry_a !== (i == 799)) $display("FAIL casc_carry cyc %0d got %b exp %b", i, carry_a, (i == 799)); else n_pass++;
      n_total++; if (q_b !== 10'd0) $display("FAIL casc_q_b cyc %0d got %0d exp 0", i, q_b); else n_pass++;
      tick();
    end
    n_total++; if (q_a !== 10'd0) $display("FAIL casc_wrap_q got %0d exp 0", q_a); else n_pass++;
    n_total++; if (roll_a !== 1'b1) $display("FAIL casc_roll got %b exp 1", roll_a); else n_pass++;
    n_total++; if (q_b !== 10'd1) $display("FAIL casc_v_step got %0d exp 1", q_b); else n_pass++;
    ctrl_b = CTRL_HOLD;
    tick();
    n_total++; if (roll_a !== 1'b0) $display("FAIL casc_roll_clear got %b exp 0", roll_a); else n_pass++;
  endtask

  task automatic test_saturate();
    wrap_en = 1'b0; limit = 10'd5; load_val = 10'd0; ctrl = CTRL_LOAD; tick();
    ctrl = CTRL_UP; cnt_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_total++; if (q_a !== 10'((i < 5) ? i : 5)) $display("FAIL sat_q cyc %0d got %0d exp %0d", i, q_a, (i < 5) ? i : 5); else n_pass++;
      n_total++; if (carry_a !== (i >= 5)) $display("FAIL sat_carry cyc %0d got %b exp %b", i, carry_a, (i >= 5)); else n_pass++;
      tick();
      n_total++; if (roll_a !== 1'b0) $display("FAIL sat_roll cyc %0d got %b exp 0", i, roll_a); else n_pass++;
    end
    n_total++; if (q_a !== 10'd5) $display("FAIL sat_final got %0d exp 5", q_a); else n_pass++;
  endtask

  task automatic test_down_wrap();
    int seq[5] = '{2, 1, 0, 9, 8};
    wrap_en = 1'b1; limit = 10'd9; load_val = 10'd2; ctrl = CTRL_LOAD; tick();
    ctrl = CTRL_DOWN; cnt_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_total++; if (q_a !== 10'(seq[k])) $display("FAIL down_q step %0d got %0d exp %0d", k, q_a, seq[k]); else n_pass++;
      n_total++; if (roll_a !== (seq[k] == 9)) $display("FAIL down_roll step %0d got %b exp %b", k, roll_a, (seq[k] == 9)); else n_pass++;
      tick();
    end
  endtask

  task automatic test_prescale();
    bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    wrap_en = 1'b1; limit = 10'd100; load_val = 10'd0; ctrl = CTRL_LOAD; tick();
    ctrl = CTRL_UP;
    for (int k = 0; k < 6; k++) begin
      cnt_in = pat[k];
      tick();
      n_total++; if (q_c !== ((k == 5) ? 10'd1 : 10'd0)) $display("FAIL ps_q step %0d got %0d exp %0d", k, q_c, (k == 5) ? 1 : 0); else n_pass++;
    end
    cnt_in = 1'b1; tick(); tick();
    ctrl = CTRL_LOAD; load_val = 10'd10; tick();
    n_total++; if (q_c !== 10'd10) $display("FAIL ps_load got %0d exp 10", q_c); else n_pass++;
    ctrl = CTRL_UP;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++; if (q_c !== ((k == 3) ? 10'd11 : 10'd10)) $display("FAIL ps_restart step %0d got %0d exp %0d", k, q_c, (k == 3) ? 11 : 10); else n_pass++;
    end
  endtask

  task automatic test_limit_shrink();
    limit = 10'd800; load_val = 10'd700; ctrl = CTRL_LOAD; tick();
    limit = 10'd300; wrap_en = 1'b1; ctrl = CTRL_UP; cnt_in = 1'b1;
    #1;
    n_total++; if (carry_a !== 1'b1) $display("FAIL shrink_up_carry got %b exp 1", carry_a); else n_pass++;
    tick();
    n_total++; if (q_a !== 10'd0) $display("FAIL shrink_wrap_q got %0d exp 0", q_a); else n_pass++;
    n_total++; if (roll_a !== 1'b1) $display("FAIL shrink_wrap_roll got %b exp 1", roll_a); else n_pass++;
    ctrl = CTRL_LOAD; tick();
    wrap_en = 1'b0; ctrl = CTRL_UP; tick();
    n_total++; if (q_a !== 10'd300) $display("FAIL shrink_sat_q got %0d exp 300", q_a); else n_pass++;
    n_total++; if (roll_a !== 1'b0) $display("FAIL shrink_sat_roll got %b exp 0", roll_a); else n_pass++;
    ctrl = CTRL_LOAD; wrap_en = 1'b1; tick();
    ctrl = CTRL_DOWN;
    #1;
    n_total++; if (carry_a !== 1'b0) $display("FAIL shrink_clamp_carry got %b exp 0", carry_a); else n_pass++;
    tick();
    n_total++; if (q_a !== 10'd300) $display("FAIL shrink_clamp_q got %0d exp 300", q_a); else n_pass++;
    n_total++; if (roll_a !== 1'b0) $display("FAIL shrink_clamp_roll got %b exp 0", roll_a); else n_pass++;
  endtask

  task automatic test_reset_mid();
    limit = 10'd123; wrap_en = 1'b1; load_val = 10'd1; ctrl = CTRL_LOAD; tick();
    ctrl = CTRL_DOWN; cnt_in = 1'b1; tick(); tick();
    n_total++; if (q_a !== 10'd123 || roll_a !== 1'b1) $display("FAIL mid_setup got q=%0d roll=%b exp q=123 roll=1", q_a, roll_a); else n_pass++;
    reset_n = 1'b0; ctrl = CTRL_UP; tick();
    reset_n = 1'b1;
    n_total++; if (q_a !== 10'd0) $display("FAIL mid_q_a got %0d exp 0", q_a); else n_pass++;
    n_total++; if (roll_a !== 1'b0) $display("FAIL mid_roll got %b exp 0", roll_a); else n_pass++;
    n_total++; if (q_c !== 10'd0) $display("FAIL mid_q_c got %0d exp 0", q_c); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++; if (q_c !== ((k == 3) ? 10'd1 : 10'd0)) $display("FAIL mid_prescale step %0d got %0d exp %0d", k, q_c, (k == 3) ? 1 : 0); else n_pass++;
    end
  endtask

  task automatic test_random();
    int r;
    logic [13:0] got;
    logic [13:0] exp;
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      r = $urandom_range(0, 9);
      ctrl = (r == 0) ? CTRL_LOAD : (r == 1) ? CTRL_HOLD : (r < 6) ? CTRL_UP : CTRL_DOWN;
      cnt_in = ($urandom_range(0, 3) != 0);
      wrap_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) limit = 10'($urandom_range(0, 12));
      load_val = 10'($urandom_range(0, 15));
      #1;
      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? {q_a, carry_a, max_a, zero_a, roll_a} : {q_c, carry_c, max_c, zero_c, roll_c};
        exp = {10'(mq[i]), m_carry(i), (mq[i] == int'(limit)), (mq[i] == 0), (mr[i] != 0)};
        n_total++;
        if (got !== exp) $display("FAIL rand inst %0d cyc %0d got %h exp %h", i, n, got, exp);
        else n_pass++;
      end
      tick();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_cascade();
    test_saturate();
    test_down_wrap();
    test_prescale();
    test_limit_shrink();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
